mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: RD_WAIT, default 1, number of idle cycles between driving dm_read_addr and sampling dm_read_data (legal 1..7).
REQ-002 Parameter: DM_TOP, default 16'hFFFC, highest implemented data-memory word address.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_f  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  requester presents a memory operation.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  16  word address.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  one-cycle pulse: operation complete.
REQ-011 resp_rdata  output  32  load result; held until the next load completes.
REQ-012 resp_err  output  1  qualifies resp_valid; operation rejected.
REQ-013 dm_read_addr  output  16  to data memory read port.
REQ-014 dm_write_addr  output  16  to data memory write port.
REQ-015 dm_write_data  output  32  to data memory write port.
REQ-016 dm_we  output  1  write strobe; memory commits on its falling edge.
REQ-017 dm_read_data  input  32  from data memory; combinationally follows dm_read_addr.

Function
REQ-018 States: IDLE, RD_ADDR, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
REQ-019 req_ready is 1 only in IDLE; a request transfers when req_valid && req_ready on a rising edge.
REQ-020 On transfer, req_addr/req_we/req_wdata are registered; later changes on req_* are ignored until the next transfer.
REQ-021 Load: IDLE -> RD_ADDR (drive dm_read_addr) -> RD_WAIT for RD_WAIT cycles (counter) -> RD_CAP (register dm_read_data into resp_rdata) -> RESP.
REQ-022 Store: IDLE -> WR_SETUP (dm_write_addr, dm_write_data driven, dm_we=0) -> WR_PULSE (dm_we=1 for exactly one cycle) -> WR_HOLD (dm_we=0; addr/data held stable through the falling edge) -> RESP.
REQ-023 dm_write_addr and dm_write_data SHALL remain stable from WR_SETUP through the end of WR_HOLD.
REQ-024 dm_we SHALL be registered, glitch-free, and high in no state other than WR_PULSE.
REQ-025 RESP: resp_valid=1 for one cycle, then IDLE; latency from transfer to resp_valid is RD_WAIT+3 cycles for loads and 4 cycles for stores.
REQ-026 A back-to-back request held on req_valid is accepted on the first cycle back in IDLE; no request is accepted during RESP.
REQ-027 A store followed by a load to the same address SHALL return the stored data (store completes before load issues).
REQ-028 resp_err is 0 unless REQ-034 applies; resp_rdata is unchanged by stores.

Reset
REQ-029 rst_f low asynchronously forces IDLE, dm_we=0, resp_valid=0, resp_err=0, resp_rdata=0, dm_read_addr=0, dm_write_addr=0, dm_write_data=0, wait counter=0.
REQ-030 Reset asserted during WR_PULSE drops dm_we immediately; that store is abandoned, no response is issued, and memory contents are unspecified for that address.
REQ-031 Reset asserted during a load abandons it; no response is issued.
REQ-032 req_ready is 1 on the first rising edge after rst_f deasserts.

Configuration
REQ-033 Macro MEM_ACCESS_CTRL_BOUNDS_EN selects address range checking.
REQ-034 With it defined: a request with req_addr > DM_TOP goes IDLE -> RESP directly, with resp_err=1 and no dm_we pulse; resp_rdata is unchanged.
REQ-035 Without it: no check; every address is passed through; resp_err is tied to 0.

Verification
REQ-036 Store 0xDEADBEEF to 0x0010 -> dm_we high for one cycle only, addr 0x0010 and data stable across the falling edge, resp_valid 4 cycles after transfer, resp_err=0.
REQ-037 Load 0x0010 after REQ-036 (RD_WAIT=1) -> resp_rdata=0xDEADBEEF with resp_valid 4 cycles after transfer.
REQ-038 req_valid held high for store A then load A back-to-back -> second request accepted on the cycle after RESP; load returns store A's data.
REQ-039 rst_f pulled low mid-WR_PULSE -> dm_we=0 with no clock edge, state IDLE, no resp_valid, req_ready=1 after release.
REQ-040 With MEM_ACCESS_CTRL_BOUNDS_EN defined, store to 0xFFFE -> resp_valid with resp_err=1 after 1 cycle, dm_we never asserted; without it, the same store pulses dm_we and resp_err=0.
REQ-041 RD_WAIT=3, load 0x0000 -> resp_valid exactly 6 cycles after transfer; dm_read_addr=0x0000 stable through RD_CAP.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single load/store requests onto a data memory
// with a separate combinational read port and a falling-edge-committed write
// strobe. Loads wait RD_WAIT idle cycles before capturing read data; stores
// use a setup / one-cycle pulse / hold sequence so that the write address and
// data are stable around the strobe's falling edge.
//
// Optional feature: define MEM_ACCESS_CTRL_BOUNDS_EN to reject requests whose
// word address lies above DM_TOP (answered immediately with resp_err=1).
module mem_access_ctrl #(
  parameter int          RD_WAIT = 1,
  parameter logic [15:0] DM_TOP  = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] dm_read_addr,
  output logic [15:0] dm_write_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_we,
  input  logic [31:0] dm_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_CAP,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RESP
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT - 1);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       addr_oob;

`ifdef MEM_ACCESS_CTRL_BOUNDS_EN
  assign addr_oob = (req_addr > DM_TOP);
`else
  logic unused_dm_top;
  assign addr_oob      = 1'b0;
  assign unused_dm_top = ^DM_TOP;
`endif

  // Request sequencer: every output is a flop so dm_we cannot glitch.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      dm_read_addr  <= '0;
      dm_write_addr <= '0;
      dm_write_data <= '0;
      dm_we         <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (addr_oob) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= S_RESP;
            end else if (req_we) begin
              dm_write_addr <= req_addr;
              dm_write_data <= req_wdata;
              state         <= S_WR_SETUP;
            end else begin
              dm_read_addr <= req_addr;
              state        <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          wait_cnt <= '0;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= S_RD_CAP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_RD_CAP: begin
          resp_rdata <= dm_read_data;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_WR_SETUP: begin
          dm_we <= 1'b1;
          state <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          dm_we <= 1'b0;
          state <= S_WR_HOLD;
        end
        S_WR_HOLD: begin
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          dm_we     <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: drives two controllers (RD_WAIT=1 and RD_WAIT=3) with the
// same request stream, each attached to its own behavioural data memory, and
// compares them every cycle against a transaction-level timing model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        req_ready [2];
  logic        resp_valid [2];
  logic        resp_err [2];
  logic        dm_we [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] dm_write_data [2];
  logic [31:0] dm_read_data [2];
  logic [15:0] dm_read_addr [2];
  logic [15:0] dm_write_addr [2];

  logic [31:0] dmem [2][65536];
  logic [31:0] mmem [2][65536];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  bit          pend [2];
  int          acc_at [2];
  int          resp_at [2];
  bit          m_store [2];
  bit          m_oob [2];
  logic [15:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_new_rdata [2];
  logic [31:0] m_rdata [2];

  int          lat_seen [2];
  logic        err_seen [2];
  logic        we_seen [2];
  logic [31:0] init_word0;

  mem_access_ctrl #(.RD_WAIT(1), .DM_TOP(16'hFFFC)) u_dut_w1 (
    .clk(clk), .rst_f(rst_f),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .dm_read_addr(dm_read_addr[0]), .dm_write_addr(dm_write_addr[0]),
    .dm_write_data(dm_write_data[0]), .dm_we(dm_we[0]), .dm_read_data(dm_read_data[0])
  );

  mem_access_ctrl #(.RD_WAIT(3), .DM_TOP(16'hFFFC)) u_dut_w3 (
    .clk(clk), .rst_f(rst_f),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .dm_read_addr(dm_read_addr[1]), .dm_write_addr(dm_write_addr[1]),
    .dm_write_data(dm_write_data[1]), .dm_we(dm_we[1]), .dm_read_data(dm_read_data[1])
  );

  assign dm_read_data[0] = dmem[0][dm_read_addr[0]];
  assign dm_read_data[1] = dmem[1][dm_read_addr[1]];

  always #5 clk = ~clk;

  // Data memories commit on the falling edge of the write strobe, but not when
  // the strobe falls because reset cut the store short.
  always @(negedge dm_we[0]) if (rst_f === 1'b1) dmem[0][dm_write_addr[0]] = dm_write_data[0];
  always @(negedge dm_we[1]) if (rst_f === 1'b1) dmem[1][dm_write_addr[1]] = dm_write_data[1];

  function automatic int rdWait(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit isOob(input logic [15:0] a);
    return BOUNDS_EN && (a > 16'hFFFC);
  endfunction

  function automatic int opLatency(input int d, input bit store, input bit oob);
    if (oob) return 1;
    if (store) return 4;
    return rdWait(d) + 3;
  endfunction

  function automatic logic [15:0] pickAddr();
    if ($urandom_range(0, 9) == 0) return 16'hFFFC + 16'($urandom_range(0, 3));
    return 16'h0010 + 16'($urandom_range(0, 15));
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, d, got, exp);
    else
      n_pass++;
  endtask

  // Transaction model: one outstanding operation per controller, response due
  // a fixed latency after acceptance, memory updated in request order.
  always @(posedge clk) begin : model
    bit rdy;
    cyc = cyc + 1;
    if (rst_f) begin
      for (int d = 0; d < 2; d++) begin
        rdy = !pend[d];
        if (pend[d]) begin
          if (cyc == resp_at[d] - 1 && !m_store[d] && !m_oob[d]) m_rdata[d] = m_new_rdata[d];
          if (cyc >= resp_at[d]) pend[d] = 1'b0;
        end
        if (rdy && req_valid) begin
          pend[d]    = 1'b1;
          acc_at[d]  = cyc;
          m_store[d] = req_we;
          m_oob[d]   = isOob(req_addr);
          m_addr[d]  = req_addr;
          m_wdata[d] = req_wdata;
          resp_at[d] = cyc + opLatency(d, req_we, isOob(req_addr));
          if (!m_oob[d] && m_store[d]) mmem[d][req_addr] = req_wdata;
          if (!m_oob[d] && !m_store[d]) m_new_rdata[d] = mmem[d][req_addr];
        end
      end
    end
  end

  // Reset abandons whatever the model had outstanding.
  always @(negedge rst_f) begin
    for (int d = 0; d < 2; d++) begin
      pend[d]    = 1'b0;
      m_rdata[d] = '0;
    end
  end

  // Every-cycle comparison of both controllers against the model.
  always @(negedge clk) begin : compare
    bit exp_rv;
    for (int d = 0; d < 2; d++) begin
      exp_rv = pend[d] && (cyc == resp_at[d] - 1);
      checkOutput("req_ready", d, 32'(req_ready[d]), 32'(!pend[d]));
      checkOutput("resp_valid", d, 32'(resp_valid[d]), 32'(exp_rv));
      checkOutput("resp_err", d, 32'(resp_err[d]), 32'(exp_rv && m_oob[d]));
      checkOutput("resp_rdata", d, resp_rdata[d], m_rdata[d]);
      checkOutput("dm_we", d, 32'(dm_we[d]),
                  32'(pend[d] && m_store[d] && !m_oob[d] && cyc == acc_at[d] + 1));
      if (pend[d] && m_store[d] && !m_oob[d] && cyc <= acc_at[d] + 2) begin
        checkOutput("dm_write_addr", d, 32'(dm_write_addr[d]), 32'(m_addr[d]));
        checkOutput("dm_write_data", d, dm_write_data[d], m_wdata[d]);
      end
      if (pend[d] && !m_store[d] && !m_oob[d] && cyc <= resp_at[d] - 2)
        checkOutput("dm_read_addr", d, 32'(dm_read_addr[d]), 32'(m_addr[d]));
    end
  end

  // Issues one request for a single cycle once both controllers are idle, then
  // records response latency, error flag and whether a write strobe appeared.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    int tries = 0;
    @(negedge clk);
    while (!(req_ready[0] && req_ready[1]) && tries < 30) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 30) checkOutput("ready_timeout", 0, 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int d = 0; d < 2; d++) begin
      lat_seen[d] = 0;
      err_seen[d] = 1'b0;
      we_seen[d]  = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    for (int n = 1; n <= 12; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (lat_seen[d] == 0 && resp_valid[d]) begin
          lat_seen[d] = n;
          err_seen[d] = resp_err[d];
        end
        if (dm_we[d]) we_seen[d] = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int b2b_lat [2];
    logic [31:0] b2b_rdata [2];
    for (int a = 0; a < 65536; a++) begin
      logic [31:0] v;
      v = $urandom;
      dmem[0][a] = v;
      dmem[1][a] = v;
      mmem[0][a] = v;
      mmem[1][a] = v;
    end
    init_word0 = dmem[0][0];
    #1 rst_f = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_ready", d, 32'(req_ready[d]), 32'd1);
      checkOutput("rst_resp_valid", d, 32'(resp_valid[d]), 32'd0);
      checkOutput("rst_rdata", d, resp_rdata[d], 32'd0);
      checkOutput("rst_dm_we", d, 32'(dm_we[d]), 32'd0);
      checkOutput("rst_wr_addr", d, 32'(dm_write_addr[d]), 32'd0);
    end
    rst_f = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput("ready_after_rst", d, 32'(req_ready[d]), 32'd1);

    $display("[TB] store 0xDEADBEEF to 0x0010");
    applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF);
    for (int d = 0; d < 2; d++) begin
      checkOutput("store_latency", d, 32'(lat_seen[d]), 32'd4);
      checkOutput("store_err", d, 32'(err_seen[d]), 32'd0);
      checkOutput("store_we_seen", d, 32'(we_seen[d]), 32'd1);
    end

    $display("[TB] load 0x0010");
    applyStimulus(1'b0, 16'h0010, 32'h0);
    checkOutput("load_latency", 0, 32'(lat_seen[0]), 32'd4);
    checkOutput("load_latency", 1, 32'(lat_seen[1]), 32'd6);
    for (int d = 0; d < 2; d++) checkOutput("load_rdata", d, resp_rdata[d], 32'hDEADBEEF);

    $display("[TB] load 0x0000");
    applyStimulus(1'b0, 16'h0000, 32'h0);
    checkOutput("load0_latency", 1, 32'(lat_seen[1]), 32'd6);
    for (int d = 0; d < 2; d++) checkOutput("load0_rdata", d, resp_rdata[d], init_word0);

    $display("[TB] store to 0xFFFE");
    applyStimulus(1'b1, 16'hFFFE, 32'h12345678);
    for (int d = 0; d < 2; d++) begin
      checkOutput("top_latency", d, 32'(lat_seen[d]), BOUNDS_EN ? 32'd1 : 32'd4);
      checkOutput("top_err", d, 32'(err_seen[d]), 32'(BOUNDS_EN));
      checkOutput("top_we_seen", d, 32'(we_seen[d]), 32'(!BOUNDS_EN));
      checkOutput("top_rdata_kept", d, resp_rdata[d], init_word0);
    end

    $display("[TB] back-to-back store then load of 0x0030");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0030;
    req_wdata = 32'hA5A5_0030;
    b2b_lat[0] = 0;
    b2b_lat[1] = 0;
    @(negedge clk);
    req_we    = 1'b0;
    req_wdata = 32'h0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 6) req_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (n > 5 && b2b_lat[d] == 0 && resp_valid[d]) begin
          b2b_lat[d]   = n;
          b2b_rdata[d] = resp_rdata[d];
        end
      end
      @(negedge clk);
    end
    checkOutput("b2b_load_cycle", 0, 32'(b2b_lat[0]), 32'd9);
    checkOutput("b2b_load_cycle", 1, 32'(b2b_lat[1]), 32'd11);
    for (int d = 0; d < 2; d++) checkOutput("b2b_rdata", d, b2b_rdata[d], 32'hA5A5_0030);

    $display("[TB] reset during write pulse");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 32'h7777_0020;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) checkOutput("pulse_before_rst", d, 32'(dm_we[d]), 32'd1);
    rst_f = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("async_dm_we", d, 32'(dm_we[d]), 32'd0);
      checkOutput("async_resp_valid", d, 32'(resp_valid[d]), 32'd0);
      checkOutput("async_ready", d, 32'(req_ready[d]), 32'd1);
    end
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) checkOutput("ready_after_release", d, 32'(req_ready[d]), 32'd1);
    applyStimulus(1'b1, 16'h0020, 32'h0BAD_F00D);
    applyStimulus(1'b0, 16'h0020, 32'h0);
    for (int d = 0; d < 2; d++) checkOutput("restore_rdata", d, resp_rdata[d], 32'h0BAD_F00D);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = pickAddr();
      req_wdata = $urandom;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
